program_memory: RTL and testbench

Parametrised, runtime-loadable successor to the fixed instruction store of the single-cycle MIPS core.
- Holds DEPTH instruction words in an inferred RAM.
- Contents are loaded at run time by a byte-serial boot-load stream. Each word is assembled MSB-first.
- The fetch port is a registered read with 1-cycle latency and a valid flag.
- Any address not yet loaded returns the all-zero word (sll $0,$0,0 = NOP).

---
 rtl/program_memory_if.sv | 25 ++
 rtl/program_memory.sv | 132 +++++++++++++
 tb/tb_program_memory.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_memory_if.sv
// Byte-serial boot-load stream into program_memory.
// master drives bytes, slave (the memory) answers with load_ready.
interface program_memory_if;
  logic       load_start;
  logic       load_valid;
  logic [7:0] load_byte;
  logic       load_last;
  logic       load_ready;

  modport master (
    output load_start,
    output load_valid,
    output load_byte,
    output load_last,
    input  load_ready
  );

  modport slave (
    input  load_start,
    input  load_valid,
    input  load_byte,
    input  load_last,
    output load_ready
  );
endinterface

// File: rtl/program_memory.sv
// Runtime-loadable instruction store: byte-serial boot load,
// registered 1-cycle fetch, unloaded words read back as NOP.
module program_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_valid,
  program_memory_if.slave       load,
  output logic                  busy,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  load_error
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = ADDR_WIDTH + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [BW-1:0] LAST_B = BW'(BYTES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] FULL = 2'd2;

  logic [1:0]            state;
  logic [BW-1:0]         byte_cnt;
  logic [IW-1:0]         ptr;
  logic [DATA_WIDTH-1:0] asm_r;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  complete;
  logic                  room;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] padded;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  hit;
  logic [IW-1:0]         rd_idx;

  assign load.load_ready = (state != IDLE);
  assign busy            = (state != IDLE);

  assign accept   = load.load_valid && load.load_ready;
  assign complete = (byte_cnt == LAST_B);
  assign room     = (word_count < DEPTH_C);

  assign shifted = (asm_r << 8) | DATA_WIDTH'(load.load_byte);
  // short word: drop the stale high bytes, zero-fill the low ones
  assign padded  = shifted << {(LAST_B - byte_cnt), 3'b000};
  assign wr_data = complete ? shifted : padded;

  assign wr_en = (state == LOAD) && accept && room
               && (complete || load.load_last);

  assign hit = ({1'b0, address} < word_count)
            && ({1'b0, address} < DEPTH_C);
  assign rd_idx = address[IW-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      ptr        <= '0;
      asm_r      <= '0;
      word_count <= '0;
      load_error <= 1'b0;
    end else begin
      unique case (1'b1)
        state == IDLE: begin
          if (load.load_start) begin
            state      <= LOAD;
            ptr        <= '0;
            byte_cnt   <= '0;
            word_count <= '0;
            load_error <= 1'b0;
          end
        end
        state == LOAD: begin
          if (accept) begin
            asm_r <= shifted;
            if (complete || load.load_last) begin
              byte_cnt <= '0;
              if (room) begin
                ptr        <= ptr + 1'b1;
                word_count <= word_count + 1'b1;
              end
              if (!complete || !room)
                load_error <= 1'b1;
              if (load.load_last)
                state <= IDLE;
              else if (!room)
                state <= FULL;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        state == FULL: begin
          if (accept && load.load_last)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en)
      mem[ptr] <= wr_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else if (read_en && (state == IDLE)) begin
      q       <= hit ? mem[rd_idx] : '0;
      q_valid <= 1'b1;
    end else begin
      q_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_program_memory.sv
// Directed plus randomized load/fetch sessions for program_memory,
// checked against a word-level model of the memory contents.
module tb_program_memory;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int DEPTH = 4;
  localparam int BYTES = DW / 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] address = '0;
  logic          read_en = 1'b0;
  logic [DW-1:0] q;
  logic          q_valid;
  logic          busy;
  logic [AW:0]   word_count;
  logic          load_error;

  program_memory_if lif ();

  program_memory #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .address(address),
    .read_en(read_en),
    .q(q),
    .q_valid(q_valid),
    .load(lif),
    .busy(busy),
    .word_count(word_count),
    .load_error(load_error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mmem [DEPTH];
  int            mcount = 0;
  bit            merr = 1'b0;
  logic [7:0]    bq [$];
  logic [DW-1:0] old;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DW-1:0] exp_fetch(int a);
    return (a < mcount) ? mmem[a] : '0;
  endfunction

  // Whole-session result: chunk bytes into words, pad the tail,
  // keep only the first DEPTH words.
  function automatic void model_apply(logic [7:0] b[$]);
    int n;
    int nw;
    logic [DW-1:0] w;
    n = b.size();
    nw = (n + BYTES - 1) / BYTES;
    mcount = 0;
    for (int i = 0; i < nw; i++) begin
      w = '0;
      for (int k = 0; k < BYTES; k++) begin
        int idx;
        idx = i * BYTES + k;
        w = {w[DW-9:0], (idx < n) ? b[idx] : 8'h00};
      end
      if (i < DEPTH) begin
        mmem[i] = w;
        mcount++;
      end
    end
    merr = ((n % BYTES) != 0) || (nw > DEPTH);
  endfunction

  task automatic fetch_chk(int a, string tag);
    address = AW'(a);
    read_en = 1'b1;
    step();
    read_en = 1'b0;
    chk({tag, "_v"}, q_valid, 1);
    chk(tag, q, exp_fetch(a));
  endtask

  task automatic fetch_const(int a, logic [DW-1:0] exp,
                             string tag);
    address = AW'(a);
    read_en = 1'b1;
    step();
    read_en = 1'b0;
    chk({tag, "_v"}, q_valid, 1);
    chk(tag, q, exp);
  endtask

  task automatic send_load(logic [7:0] b[$], bit gaps,
                           bit poke);
    lif.load_start = 1'b1;
    step();
    lif.load_start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_err_clr", load_error, 0);
    chk("start_cnt_clr", word_count, 0);
    foreach (b[i]) begin
      if (gaps)
        repeat ($urandom_range(0, 1)) step();
      lif.load_valid = 1'b1;
      lif.load_byte  = b[i];
      lif.load_last  = (i == b.size() - 1);
      if (poke && i == 1)
        lif.load_start = 1'b1;
      step();
      lif.load_valid = 1'b0;
      lif.load_last  = 1'b0;
      lif.load_start = 1'b0;
    end
    model_apply(b);
    chk("end_busy", busy, 0);
    chk("word_count", word_count, mcount);
    chk("load_error", load_error, merr);
  endtask

  initial begin
    lif.load_start = 1'b0;
    lif.load_valid = 1'b0;
    lif.load_byte  = '0;
    lif.load_last  = 1'b0;
    step();
    chk("rst_q", q, 0);
    chk("rst_qv", q_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", word_count, 0);
    chk("rst_err", load_error, 0);
    chk("rst_ready", lif.load_ready, 0);
    reset_n = 1'b1;
    step();

    fetch_const(0, 32'h0, "t1_addr0");

    bq = '{8'h20, 8'h01, 8'h00, 8'h03,
           8'h20, 8'h02, 8'h00, 8'h00,
           8'h20, 8'h42, 8'h00, 8'h01};
    send_load(bq, 1'b0, 1'b0);
    chk("t2_cnt", word_count, 3);
    chk("t2_err", load_error, 0);
    fetch_const(0, 32'h20010003, "t2_a0");
    fetch_const(1, 32'h20020000, "t2_a1");
    fetch_const(2, 32'h20420001, "t2_a2");
    fetch_const(3, 32'h00000000, "t2_a3");

    bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    send_load(bq, 1'b0, 1'b0);
    chk("t3_cnt", word_count, 2);
    chk("t3_err", load_error, 1);
    fetch_const(0, 32'hAABBCCDD, "t3_a0");
    fetch_const(1, 32'h11220000, "t3_a1");
    fetch_const(2, 32'h00000000, "t3_a2");

    bq.delete();
    for (int i = 1; i <= 20; i++) bq.push_back(8'(i));
    send_load(bq, 1'b0, 1'b0);
    chk("t4_cnt", word_count, 4);
    chk("t4_err", load_error, 1);
    fetch_const(3, 32'h0D0E0F10, "t4_a3");
    fetch_const(4, 32'h0, "t4_a4");

    bq.delete();
    for (int i = 0; i < 24; i++) bq.push_back(8'(8'h40 + i));
    send_load(bq, 1'b1, 1'b0);
    fetch_chk(0, "t4b_a0");
    fetch_chk(3, "t4b_a3");

    old = exp_fetch(0);
    address = '0;
    read_en = 1'b1;
    lif.load_start = 1'b1;
    step();
    lif.load_start = 1'b0;
    chk("t5_start_v", q_valid, 1);
    chk("t5_start_q", q, old);
    chk("t5_busy", busy, 1);
    address = 8'd1;
    bq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    foreach (bq[k]) begin
      lif.load_valid = 1'b1;
      lif.load_byte  = bq[k];
      lif.load_last  = (k == 3);
      step();
      chk("t5_hold_v", q_valid, 0);
      chk("t5_hold_q", q, old);
    end
    lif.load_valid = 1'b0;
    lif.load_last  = 1'b0;
    model_apply(bq);
    step();
    read_en = 1'b0;
    chk("t5_after_v", q_valid, 1);
    chk("t5_after_q", q, exp_fetch(1));
    fetch_const(0, 32'hDEADBEEF, "t5_a0");

    lif.load_valid = 1'b1;
    lif.load_byte  = 8'hFF;
    lif.load_last  = 1'b1;
    step();
    step();
    lif.load_valid = 1'b0;
    lif.load_last  = 1'b0;
    chk("idle_valid_busy", busy, 0);
    chk("idle_valid_cnt", word_count, mcount);

    lif.load_start = 1'b1;
    step();
    lif.load_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      lif.load_valid = 1'b1;
      lif.load_byte  = 8'(8'h90 + i);
      step();
    end
    lif.load_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_cnt", word_count, 0);
    chk("t6_ready", lif.load_ready, 0);
    mcount = 0;
    merr = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    fetch_const(0, 32'h0, "t6_a0");
    bq = '{8'h01, 8'h23, 8'h45, 8'h67,
           8'h89, 8'hAB, 8'hCD, 8'hEF};
    send_load(bq, 1'b0, 1'b0);
    fetch_const(0, 32'h01234567, "t6_new_a0");
    fetch_const(1, 32'h89ABCDEF, "t6_new_a1");

    repeat (20) begin
      int n;
      n = $urandom_range(1, 22);
      bq.delete();
      for (int i = 0; i < n; i++)
        bq.push_back(8'($urandom_range(0, 255)));
      send_load(bq, 1'b1, 1'($urandom_range(0, 1)));
      for (int a = 0; a < 6; a++) fetch_chk(a, "rnd_fetch");
      fetch_chk($urandom_range(0, 255), "rnd_addr");
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
